// File: rtl/muldiv_sequencer_pkg.sv
// Shared SPECIAL funct codes and decode helpers for the HI/LO multiply/divide unit.
package muldiv_sequencer_pkg;

    localparam logic [5:0] SPECIAL_MFHI  = 6'h10;
    localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
    localparam logic [5:0] SPECIAL_MFLO  = 6'h12;
    localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
    localparam logic [5:0] SPECIAL_MULT  = 6'h18;
    localparam logic [5:0] SPECIAL_MULTU = 6'h19;
    localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
    localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

    // Any funct that touches HI/LO must wait for an in-flight iteration.
    function automatic logic is_hilo_op(input logic [5:0] funct);
        return funct inside {SPECIAL_MFHI, SPECIAL_MTHI, SPECIAL_MFLO, SPECIAL_MTLO,
                             SPECIAL_MULT, SPECIAL_MULTU, SPECIAL_DIV, SPECIAL_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on magnitudes.
module muldiv_iter_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH:0]   hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH:0]   b_r;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // Multiply: {carry, hi, lo} shifts right; lo starts as multiplier.
    // Divide: {hi, lo} shifts left; lo collects quotient bits, hi holds remainder.
    always_comb begin
        mul_sum   = hi_r + (lo_r[0] ? b_r : '0);
        div_shift = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
        div_ge    = (div_shift >= b_r);
        div_diff  = div_shift - b_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
            b_r  <= '0;
        end else if (load) begin
            hi_r <= '0;
            lo_r <= a_in;
            b_r  <= {1'b0, b_in};
        end else if (step) begin
            if (is_div) begin
                hi_r <= div_ge ? div_diff : div_shift;
                lo_r <= {lo_r[WIDTH-2:0], div_ge};
            end else begin
                hi_r <= {1'b0, mul_sum[WIDTH:1]};
                lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
            end
        end
    end

    assign hi = hi_r[WIDTH-1:0];
    assign lo = lo_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; stalls HI/LO ops while iterating.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             w_clock,
    input  logic             w_reset_n,
    input  logic             w_start,
    input  logic [5:0]       w_op_code_6,
    input  logic [WIDTH-1:0] w_input1_x,
    input  logic [WIDTH-1:0] w_input2_x,
    output logic             w_stall,
    output logic             w_busy,
    output logic             w_done,
    output logic             w_div_by_zero,
    output logic [WIDTH-1:0] w_result_x,
    output logic [WIDTH-1:0] w_hi_x,
    output logic [WIDTH-1:0] w_lo_x
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi_reg, lo_reg, dp_hi, dp_lo;
    logic               op_div_r, dbz_r, neg_q_r, neg_r_r;
    logic               is_mul, is_div, is_signed, dbz_start, accept;
    logic [WIDTH-1:0]   abs1, abs2, a_ld, b_ld;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        is_mul    = (w_op_code_6 == SPECIAL_MULT) || (w_op_code_6 == SPECIAL_MULTU);
        is_div    = (w_op_code_6 == SPECIAL_DIV)  || (w_op_code_6 == SPECIAL_DIVU);
        is_signed = (w_op_code_6 == SPECIAL_MULT) || (w_op_code_6 == SPECIAL_DIV);
        dbz_start = is_div && (w_input2_x == '0);
        abs1      = w_input1_x[WIDTH-1] ? -w_input1_x : w_input1_x;
        abs2      = w_input2_x[WIDTH-1] ? -w_input2_x : w_input2_x;
        // Divide-by-zero keeps raw rs in the datapath so FIX can copy it to HI.
        a_ld      = (is_signed && !dbz_start) ? abs1 : w_input1_x;
        b_ld      = is_signed ? abs2 : w_input2_x;
    end

    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        w_busy        = (state != IDLE);
        w_done        = (state == FIX);
        w_div_by_zero = (state == FIX) && dbz_r;
        w_stall       = (state != IDLE) && w_start && is_hilo_op(w_op_code_6);
        case (state)
            IDLE: if (w_start && (is_mul || is_div)) begin
                accept     = 1'b1;
                next_state = dbz_start ? FIX : RUN;
            end
            RUN:  if (cnt == '0) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) state <= IDLE;
        else            state <= next_state;
    end

    muldiv_iter_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (w_clock),
        .rst_n  (w_reset_n),
        .load   (accept),
        .step   (state == RUN),
        .is_div (op_div_r),
        .a_in   (a_ld),
        .b_in   (b_ld),
        .hi     (dp_hi),
        .lo     (dp_lo)
    );

    always_comb begin
        prod_fix = neg_q_r ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
        quot_fix = neg_q_r ? -dp_lo : dp_lo;
        rem_fix  = neg_r_r ? -dp_hi : dp_hi;
    end

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            cnt      <= '0;
            op_div_r <= 1'b0;
            dbz_r    <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
        end else begin
            if (accept) begin
                cnt      <= CNT_W'(WIDTH - 1);
                op_div_r <= is_div;
                dbz_r    <= dbz_start;
                neg_q_r  <= is_signed && (w_input1_x[WIDTH-1] ^ w_input2_x[WIDTH-1]);
                neg_r_r  <= is_signed && w_input1_x[WIDTH-1];
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (state == FIX) begin
                if (dbz_r) begin
                    hi_reg <= dp_lo;
                    lo_reg <= '1;
                end else if (op_div_r) begin
                    hi_reg <= rem_fix;
                    lo_reg <= quot_fix;
                end else begin
                    {hi_reg, lo_reg} <= prod_fix;
                end
            end else if (state == IDLE && w_start) begin
                if (w_op_code_6 == SPECIAL_MTHI) hi_reg <= w_input1_x;
                if (w_op_code_6 == SPECIAL_MTLO) lo_reg <= w_input1_x;
            end
        end
    end

    assign w_result_x = (w_op_code_6 == SPECIAL_MFHI) ? hi_reg :
                        (w_op_code_6 == SPECIAL_MFLO) ? lo_reg : '0;
    assign w_hi_x = hi_reg;
    assign w_lo_x = lo_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO queued at issue, checked on done.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [5:0]   op;
    logic [W-1:0] in1, in2;
    logic         stall, busy, done, dbz;
    logic [W-1:0] result, hi, lo;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic pend = 1'b0;
    exp_t pend_exp;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .w_clock       (clk),
        .w_reset_n     (rst_n),
        .w_start       (start),
        .w_op_code_6   (op),
        .w_input1_x    (in1),
        .w_input2_x    (in2),
        .w_stall       (stall),
        .w_busy        (busy),
        .w_done        (done),
        .w_div_by_zero (dbz),
        .w_result_x    (result),
        .w_hi_x        (hi),
        .w_lo_x        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb2, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        e   = '0;
        case (f)
            SPECIAL_MULT:  begin sp = sa * sb2; {e.hi, e.lo} = sp; end
            SPECIAL_MULTU: begin up = ua * ub;  {e.hi, e.lo} = up; end
            default: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.dbz = 1'b1;
                end else if (f == SPECIAL_DIV) begin
                    sq = sa / sb2; sr = sa % sb2;
                    e.lo = sq[W-1:0]; e.hi = sr[W-1:0];
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    e.lo = uq[W-1:0]; e.hi = ur[W-1:0];
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard: pop on done, check flag now and HI/LO one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            checks += 2;
            if (hi !== pend_exp.hi) begin failures++; $display("FAIL sb_hi got=%h exp=%h", hi, pend_exp.hi); end
            if (lo !== pend_exp.lo) begin failures++; $display("FAIL sb_lo got=%h exp=%h", lo, pend_exp.lo); end
            pend = 1'b0;
        end
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL unexpected_done got=1 exp=0");
            end else begin
                pend_exp = sb.pop_front();
                pend = 1'b1;
                if (dbz !== pend_exp.dbz) begin failures++; $display("FAIL sb_dbz got=%b exp=%b", dbz, pend_exp.dbz); end
            end
        end else if (dbz !== 1'b0) begin
            checks++; failures++; $display("FAIL dbz_outside_done got=%b exp=0", dbz);
        end
    end

    // Issue at the current negedge; returns at the negedge after HI/LO become visible.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        int n;
        sb.push_back(model(f, a, b));
        start = 1'b1; op = f; in1 = a; in2 = b;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL issue_stall got=%b exp=0", stall); end
        @(negedge clk);
        start = 1'b0; op = 6'h00;
        n = 1;
        while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != lat) begin failures++; $display("FAIL done_latency op=%h got=%0d exp=%0d", f, n, lat); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        start = 1'b1; op = SPECIAL_MFHI;
        #1;
        checks += 6;
        if (busy   !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done   !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        if (stall  !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
        if (hi     !== '0)   begin failures++; $display("FAIL rst_hi got=%h exp=0", hi); end
        if (lo     !== '0)   begin failures++; $display("FAIL rst_lo got=%h exp=0", lo); end
        if (result !== '0)   begin failures++; $display("FAIL rst_result got=%h exp=0", result); end
        start = 1'b0; op = 6'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        do_op(SPECIAL_MULT, 32'hFFFFFFFD, 32'd7, 33);
        checks += 2;
        if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=FFFFFFFF", hi); end
        if (lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=FFFFFFEB", lo); end
        do_op(SPECIAL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        checks += 2;
        if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_max_hi got=%h exp=FFFFFFFE", hi); end
        if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_max_lo got=%h exp=00000001", lo); end
        do_op(SPECIAL_MULT, 32'h80000000, 32'h80000000, 33);
        for (int i = 0; i < 3; i++) begin
            do_op(SPECIAL_MULT,  $urandom, $urandom, 33);
            do_op(SPECIAL_MULTU, $urandom, $urandom, 33);
        end
    endtask

    task automatic test_div();
        do_op(SPECIAL_DIV, 32'hFFFFFFF9, 32'd2, 33);
        checks += 2;
        if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=FFFFFFFD", lo); end
        if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=FFFFFFFF", hi); end
        do_op(SPECIAL_DIVU, 32'd7, 32'd2, 33);
        do_op(SPECIAL_DIV, 32'h80000000, 32'hFFFFFFFF, 33);
        checks += 2;
        if (lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        if (hi !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
        do_op(SPECIAL_DIV, 32'd5, 32'd0, 1);
        checks += 2;
        if (hi !== 32'd5)        begin failures++; $display("FAIL dbz_hi got=%h exp=00000005", hi); end
        if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL dbz_lo got=%h exp=FFFFFFFF", lo); end
        do_op(SPECIAL_DIV,  32'hFFFFFFFB, 32'd0, 1);
        do_op(SPECIAL_DIVU, 32'hFFFFFFFF, 32'd1, 33);
        do_op(SPECIAL_DIV,  32'd7, 32'hFFFFFFFE, 33);
        for (int i = 0; i < 3; i++) begin
            do_op(SPECIAL_DIV,  $urandom, $urandom_range(1, 1000), 33);
            do_op(SPECIAL_DIVU, $urandom, $urandom, 33);
        end
    endtask

    task automatic test_stall();
        int n;
        sb.push_back(model(SPECIAL_MULT, 32'd6, 32'd7));
        start = 1'b1; op = SPECIAL_MULT; in1 = 32'd6; in2 = 32'd7;
        @(negedge clk);
        op = SPECIAL_MFLO;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin n++; @(negedge clk); #1; end
        checks += 2;
        if (n != 33)           begin failures++; $display("FAIL mflo_stall_cycles got=%0d exp=33", n); end
        if (result !== 32'h2A) begin failures++; $display("FAIL mflo_result got=%h exp=0000002A", result); end
        start = 1'b0; op = 6'h00;
        @(negedge clk);

        sb.push_back(model(SPECIAL_MULT, 32'd2, 32'd3));
        start = 1'b1; op = SPECIAL_MULT; in1 = 32'd2; in2 = 32'd3;
        @(negedge clk);
        op = SPECIAL_MULTU; in1 = 32'd4; in2 = 32'd5;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin n++; @(negedge clk); #1; end
        checks++;
        if (n != 33) begin failures++; $display("FAIL mult_busy_stall got=%0d exp=33", n); end
        sb.push_back(model(SPECIAL_MULTU, 32'd4, 32'd5));
        @(negedge clk);
        op = 6'h20;
        #1;
        checks += 2;
        if (busy !== 1'b1)  begin failures++; $display("FAIL busy_after_accept got=%b exp=1", busy); end
        if (stall !== 1'b0) begin failures++; $display("FAIL nonhilo_stall got=%b exp=0", stall); end
        start = 1'b0; op = 6'h00;
        n = 0;
        while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (lo !== 32'd20) begin failures++; $display("FAIL held_multu_lo got=%h exp=00000014", lo); end
    endtask

    task automatic test_mt();
        start = 1'b1; op = SPECIAL_MTHI; in1 = 32'h1234;
        @(negedge clk);
        op = SPECIAL_MTLO; in1 = 32'hABCD;
        @(negedge clk);
        op = SPECIAL_MFHI;
        #1;
        checks++;
        if (result !== 32'h1234) begin failures++; $display("FAIL mfhi_result got=%h exp=00001234", result); end
        op = SPECIAL_MFLO;
        #1;
        checks += 2;
        if (result !== 32'hABCD) begin failures++; $display("FAIL mflo_after_mtlo got=%h exp=0000ABCD", result); end
        if (stall !== 1'b0)      begin failures++; $display("FAIL mf_idle_stall got=%b exp=0", stall); end
        start = 1'b0; op = 6'h00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = SPECIAL_DIV; in1 = 32'd100; in2 = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 6'h00;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (hi !== '0)     begin failures++; $display("FAIL abort_hi got=%h exp=0", hi); end
        if (lo !== '0)     begin failures++; $display("FAIL abort_lo got=%h exp=0", lo); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        start = 1'b1; op = SPECIAL_MTHI; in1 = 32'h1234;
        @(negedge clk);
        op = SPECIAL_MFHI;
        #1;
        checks++;
        if (result !== 32'h1234) begin failures++; $display("FAIL post_reset_mfhi got=%h exp=00001234", result); end
        start = 1'b0; op = 6'h00;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 6'h00; in1 = '0; in2 = '0;
        #12;
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mt();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
